dmx_frame_ctrl: RTL
===================

DMX_FRAME_CTRL -- requirements
Module: dmx_frame_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12090000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 250000, DMX bit rate.
REQ-003 SHALL have parameter NUM_SLOTS, default 16, maximum data slots per frame.
REQ-004 Port clk  input  1  system clock.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port enable  input  1  high: transmit frames periodically; low: finish the current frame, then idle.
REQ-007 Port period_sel  input  2  frame period: 00 = CLK_FREQ/10, 01 = CLK_FREQ/20, 10 = CLK_FREQ/30, 11 = CLK_FREQ/40 cycles.
REQ-008 Port slot_count  input  5  data slots sent per frame, sampled at frame start; values above NUM_SLOTS clamp to NUM_SLOTS.
REQ-009 Port wr_en  input  1  host write strobe into the shadow slot buffer.
REQ-010 Port wr_addr  input  4  shadow slot index.
REQ-011 Port wr_data  input  8  slot value.
REQ-012 Port update  input  1  one-cycle request to commit the shadow buffer to the active buffer at the next frame start.
REQ-013 Port tx  output  1  DMX line (RS-485 driver input).
REQ-014 Port busy  output  1  high from BREAK entry through DONE.
REQ-015 Port frame_done  output  1  one-cycle pulse on entry to DONE.

Function
REQ-016 SHALL derive the timing constants BIT_CYC = CLK_FREQ/BAUD_RATE (48), BREAK_CYC = (CLK_FREQ/1000000)*180 (2160) and MAB_CYC = (CLK_FREQ/1000000)*20 (240).
REQ-017 SHALL run the FSM states IDLE, BREAK, MAB, START, SLOTS and DONE.
REQ-018 IDLE -> BREAK when enable=1 and the period counter has reached its terminal value, or on the first cycle enable is high after idle.
REQ-019 Period counter:
- restarts at 0 on BREAK entry;
- counts every cycle;
- saturates at its terminal value.
- If a frame outlasts the period, the next frame starts on the cycle after DONE.
REQ-020 BREAK: tx=0 for exactly BREAK_CYC cycles, then MAB.
REQ-021 MAB: tx=1 for exactly MAB_CYC cycles, then START.
REQ-022 START: issue byte 0x00 to the serializer; on serializer done, go to SLOTS, or to DONE if slot_count=0.
REQ-023 SLOTS:
- issue active[0] through active[slot_count-1] in order;
- each byte is sent as 1 start bit (0), 8 data bits LSB first and 2 stop bits (1), each BIT_CYC cycles, 11*BIT_CYC cycles per byte;
- the next byte starts on the cycle after the previous byte's done, with no inter-slot gap.
REQ-024 DONE: lasts one cycle; frame_done=1; go to IDLE.
REQ-025 tx SHALL be 1 in IDLE and DONE.
REQ-026 A write with wr_en=1 updates shadow[wr_addr] on the same edge; a wr_addr at or above NUM_SLOTS is ignored.
REQ-027 update sets a pending flag. On the IDLE->BREAK edge, if the flag is set, the active buffer is copied from the shadow buffer and the flag is cleared.
REQ-028 A write in the same cycle as the copy lands in the shadow buffer only and is not sent in that frame.
REQ-029 update asserted in the same cycle as the IDLE->BREAK edge SHALL NOT be committed until the following frame.
REQ-030 Deasserting enable mid-frame SHALL NOT truncate the frame; the FSM idles after DONE.
REQ-031 A period_sel change takes effect at the next period-counter compare; slot_count is frozen for the duration of the frame.

Reset
REQ-032 On rst_n=0: tx=1, busy=0, frame_done=0, state=IDLE, period counter=0, pending flag=0, and both buffers all zero.
REQ-033 Reset mid-frame SHALL return tx to 1 immediately (asynchronously).

Structure
REQ-034 The DMX timing constants, the period_sel decode and the FSM state encoding SHALL live in a shared package, dmx_pkg.
REQ-035 The byte serialization SHALL be one sub-module, dmx_byte_ser, with the ports:
- clk, rst_n;
- start, data[7:0];
- ser_tx, done (1-cycle pulse), ready.
REQ-036 dmx_frame_ctrl SHALL multiplex tx between the BREAK/MAB levels and ser_tx.

Verification
REQ-037 Reset release, then enable=1, slot_count=0 -> tx low for 2160 cycles, high for 240 cycles, 528 cycles of start code 0x00, and frame_done pulses once.
REQ-038 Write shadow[0]=0xA5 and shadow[1]=0x3C, pulse update, slot_count=2 -> the bits after the start code are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0 (LSB first), each framed by a start bit and 2 stop bits.
REQ-039 period_sel=11, enable held high -> consecutive BREAK falling edges are 302250 cycles apart.
REQ-040 Write with no update pulse -> the next frame still sends the old active values (0x00).
REQ-041 Drop enable halfway through slot 1 -> the frame completes, frame_done pulses, and tx stays 1 with busy=0 thereafter.
REQ-042 Assert rst_n low mid-SLOTS -> tx=1 and busy=0 asynchronously; after release, enable=1 restarts with a full BREAK.

Source files
------------

// File: rtl/dmx_pkg.sv
// Shared DMX512 definitions: timing constants, frame-period decode and the
// frame controller state encoding.
package dmx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_MAB,
    ST_START,
    ST_SLOTS,
    ST_DONE
  } dmx_state_t;

  localparam int         BREAK_US   = 180;
  localparam int         MAB_US     = 20;
  localparam int         BYTE_BITS  = 11;  // start + 8 data + 2 stop
  localparam logic [7:0] START_CODE = 8'h00;

  function automatic int dmx_bit_cyc(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int dmx_break_cyc(input int clk_freq);
    return (clk_freq / 1000000) * BREAK_US;
  endfunction

  function automatic int dmx_mab_cyc(input int clk_freq);
    return (clk_freq / 1000000) * MAB_US;
  endfunction

  // Each branch divides by a constant so the decode folds to a 4-way mux.
  function automatic int dmx_period_cyc(input int clk_freq, input logic [1:0] sel);
    case (sel)
      2'b00:   return clk_freq / 10;
      2'b01:   return clk_freq / 20;
      2'b10:   return clk_freq / 30;
      default: return clk_freq / 40;
    endcase
  endfunction

endpackage

// File: rtl/dmx_byte_ser.sv
// DMX byte serializer: 1 start bit, 8 data bits LSB first, 2 stop bits.
// done is asserted in the last cycle of the last stop bit so a new start can be
// accepted back-to-back without an idle gap on the line.
module dmx_byte_ser
  import dmx_pkg::*;
#(
  parameter int BIT_CYC = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ser_tx,
  output logic       done,
  output logic       ready
);

  localparam int CYC_W = $clog2(BIT_CYC + 1);
  localparam int BIT_W = $clog2(BYTE_BITS + 1);

  logic                 active_q;
  logic [BYTE_BITS-1:0] shreg_q;
  logic [BIT_W-1:0]     bit_q;
  logic [CYC_W-1:0]     cyc_q;
  logic                 bit_end;
  logic                 last;

  assign bit_end = (cyc_q == CYC_W'(BIT_CYC - 1));
  assign last    = active_q && bit_end && (bit_q == BIT_W'(BYTE_BITS - 1));
  assign done    = last;
  assign ready   = !active_q || last;
  assign ser_tx  = active_q ? shreg_q[0] : 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      shreg_q  <= '1;
      bit_q    <= '0;
      cyc_q    <= '0;
    end else if (start && ready) begin
      active_q <= 1'b1;
      shreg_q  <= {2'b11, data, 1'b0};
      bit_q    <= '0;
      cyc_q    <= '0;
    end else if (active_q) begin
      if (bit_end) begin
        cyc_q <= '0;
        if (last) begin
          active_q <= 1'b0;
        end else begin
          bit_q   <= bit_q + 1'b1;
          shreg_q <= {1'b1, shreg_q[BYTE_BITS-1:1]};
        end
      end else begin
        cyc_q <= cyc_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmx_frame_ctrl.sv
// DMX512 frame controller: periodic BREAK / MAB / start code / slot frames
// from a double-buffered slot memory, committed on host request at frame start.
module dmx_frame_ctrl
  import dmx_pkg::*;
#(
  parameter int CLK_FREQ  = 12090000,
  parameter int BAUD_RATE = 250000,
  parameter int NUM_SLOTS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] period_sel,
  input  logic [4:0] slot_count,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       update,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BIT_CYC   = dmx_bit_cyc(CLK_FREQ, BAUD_RATE);
  localparam int BREAK_CYC = dmx_break_cyc(CLK_FREQ);
  localparam int MAB_CYC   = dmx_mab_cyc(CLK_FREQ);
  localparam int PER_MAX   = dmx_period_cyc(CLK_FREQ, 2'b00);
  localparam int PER_W     = $clog2(PER_MAX + 1);
  localparam int TMR_W     = $clog2(BREAK_CYC + 1);
  localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  dmx_state_t       state_q, state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [PER_W-1:0] per_q, per_term;
  logic             per_hit;
  logic             en_seen_q;
  logic             pend_q;
  logic [4:0]       slots_q, sent_q, slots_clamped;
  logic [7:0]       shadow_q [NUM_SLOTS];
  logic [7:0]       active_q [NUM_SLOTS];
  logic             go, brk_end, mab_end;
  logic             ser_req, ser_start, ser_tx, ser_done, ser_ready;
  logic [7:0]       ser_data;

  assign per_term      = PER_W'(dmx_period_cyc(CLK_FREQ, period_sel) - 1);
  assign per_hit       = (per_q >= per_term);
  assign slots_clamped = (int'(slot_count) > NUM_SLOTS) ? 5'(NUM_SLOTS) : slot_count;
  // A fresh rising enable starts at once; while held, frames follow the period.
  assign go            = (state_q == ST_IDLE) && enable && (!en_seen_q || per_hit);
  assign brk_end       = (state_q == ST_BREAK) && (tmr_q == TMR_W'(BREAK_CYC - 1));
  assign mab_end       = (state_q == ST_MAB) && (tmr_q == TMR_W'(MAB_CYC - 1));
  assign ser_start     = ser_req && ser_ready;

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ser_req  = 1'b0;
    ser_data = START_CODE;
    case (state_q)
      ST_IDLE:  if (go) state_d = ST_BREAK;
      ST_BREAK: if (brk_end) state_d = ST_MAB;
      // Start code is launched on the final MAB cycle so its start bit
      // begins exactly when MAB ends.
      ST_MAB: begin
        if (mab_end) begin
          ser_req = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START, ST_SLOTS: begin
        if (ser_done) begin
          if (sent_q == slots_q) begin
            state_d = ST_DONE;
          end else begin
            ser_req  = 1'b1;
            ser_data = active_q[sent_q[IDX_W-1:0]];
            state_d  = ST_SLOTS;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q     <= '0;
      per_q     <= '0;
      en_seen_q <= 1'b0;
      slots_q   <= '0;
      sent_q    <= '0;
    end else begin
      if (state_q != state_d)
        tmr_q <= '0;
      else if (state_q == ST_BREAK || state_q == ST_MAB)
        tmr_q <= tmr_q + 1'b1;

      if (go)           per_q <= '0;
      else if (!per_hit) per_q <= per_q + 1'b1;

      if (!enable)  en_seen_q <= 1'b0;
      else if (go)  en_seen_q <= 1'b1;

      if (go) slots_q <= slots_clamped;

      if (go)
        sent_q <= '0;
      else if (ser_start && state_q != ST_MAB)
        sent_q <= sent_q + 1'b1;
    end
  end

  // NOTE: the slot buffers are small register files whose power-up contents
  // go out on the line, so they are reset like ordinary state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wr_en && int'(wr_addr) < NUM_SLOTS)
        shadow_q[wr_addr] <= wr_data;
      // Copy sees the pre-edge shadow, so a same-edge write waits a frame.
      if (go && pend_q) begin
        for (int i = 0; i < NUM_SLOTS; i++)
          active_q[i] <= shadow_q[i];
      end
      if (update)  pend_q <= 1'b1;
      else if (go) pend_q <= 1'b0;
    end
  end

  dmx_byte_ser #(
    .BIT_CYC (BIT_CYC)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (ser_start),
    .data   (ser_data),
    .ser_tx (ser_tx),
    .done   (ser_done),
    .ready  (ser_ready)
  );

  always_comb begin
    case (state_q)
      ST_BREAK:           tx = 1'b0;
      ST_MAB:             tx = 1'b1;
      ST_START, ST_SLOTS: tx = ser_tx;
      default:            tx = 1'b1;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

endmodule
